// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : int_ctrl
// Description : Interrupt controller feeding the pipelined MIPS core's INT
//               input. Synchronizes NSRC peripheral lines, latches edge or
//               level events into PEND, applies MASK, and resolves a fixed
//               lowest-index-wins priority into a registered request and ID.
//
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous active-low reset
//               irq_i      - raw asynchronous interrupt lines (active high)
//               int_ack    - one-cycle handler-entry acknowledge from CoPR0
//               bus_sel    - register window selected
//               bus_we     - write strobe (qualified by bus_sel)
//               bus_addr   - word offset: 0=PEND 1=MASK 2=CAUSE 3=EDGE_SEL
//               bus_wdata  - write data
//               bus_rdata  - combinational read data, 0 when not selected
//               int_o      - registered interrupt request
//               int_id     - registered winning source index
//
// Build macro : INTC_SYNC_EN - when defined, irq_i passes through a 2-flop
//               synchronizer; otherwise a single sample flop is used (only
//               suitable for synchronous on-chip sources).
//
// Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int          NSRC       = 8,
    parameter logic [31:0] RESET_EDGE = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_i,
    input  logic            int_ack,
    input  logic            bus_sel,
    input  logic            bus_we,
    input  logic [1:0]      bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            int_o,
    output logic [4:0]      int_id
);

    localparam logic [1:0] c_ADDR_PEND  = 2'd0;
    localparam logic [1:0] c_ADDR_MASK  = 2'd1;
    localparam logic [1:0] c_ADDR_CAUSE = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE  = 2'd3;

    logic [NSRC-1:0] r_s;
    logic [NSRC-1:0] r_prev;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge;
    logic            r_int_o;
    logic [4:0]      r_int_id;

    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_act;
    logic [4:0]      w_enc;
    logic            w_wr;
    logic            w_wr_mask;
    logic            w_wr_edge;
    logic [31:0]     w_rdata;
    logic            w_unused;

    // ------------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------------
`ifdef INTC_SYNC_EN
    logic [NSRC-1:0] r_meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= '0;
            r_s    <= '0;
        end else begin
            r_meta <= irq_i;
            r_s    <= r_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s <= '0;
        end else begin
            r_s <= irq_i;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------------
    assign w_wr      = bus_sel & bus_we;
    assign w_wr_mask = w_wr & (bus_addr == c_ADDR_MASK);
    assign w_wr_edge = w_wr & (bus_addr == c_ADDR_EDGE);
    assign w_w1c     = (w_wr && (bus_addr == c_ADDR_PEND)) ? bus_wdata[NSRC-1:0] : '0;

    // Write data bits at or above NSRC have no destination.
    assign w_unused  = &{1'b0, bus_wdata};

    assign w_set     = r_s & ~r_prev;

    // ------------------------------------------------------------------------
    // Per-source pending logic. Edge sources: a new event beats any clear in
    // the same cycle so nothing is lost. Level sources simply mirror the
    // synchronized line and ignore W1C / ack.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_pend
            localparam logic [4:0] c_IDX = 5'(i);

            // Ack only counts while a request is actually being presented,
            // and targets the ID registered at that moment.
            assign w_ack_clr[i]  = int_ack & r_int_o & (r_int_id == c_IDX);
            assign w_pend_nxt[i] = r_edge[i]
                                 ? (w_set[i] | (r_pend[i] & ~(w_w1c[i] | w_ack_clr[i])))
                                 : r_s[i];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Priority resolution: lowest active index wins
    // ------------------------------------------------------------------------
    assign w_act = r_pend & r_mask;

    always_comb begin
        w_enc = '0;
        for (int j = NSRC - 1; j >= 0; j--) begin
            if (w_act[j]) begin
                w_enc = 5'(j);
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev   <= '0;
            r_pend   <= '0;
            r_mask   <= '0;
            r_edge   <= RESET_EDGE[NSRC-1:0];
            r_int_o  <= 1'b0;
            r_int_id <= '0;
        end else begin
            r_prev  <= r_s;
            r_pend  <= w_pend_nxt;
            r_int_o <= |w_act;
            // With nothing active the last winner is kept visible in CAUSE.
            if (|w_act) begin
                r_int_id <= w_enc;
            end
            if (w_wr_mask) begin
                r_mask <= bus_wdata[NSRC-1:0];
            end
            if (w_wr_edge) begin
                r_edge <= bus_wdata[NSRC-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (bus_sel) begin
            case (bus_addr)
                c_ADDR_PEND:  w_rdata[NSRC-1:0] = r_pend;
                c_ADDR_MASK:  w_rdata[NSRC-1:0] = r_mask;
                c_ADDR_CAUSE: w_rdata = {r_int_o, 26'b0, r_int_id};
                c_ADDR_EDGE:  w_rdata[NSRC-1:0] = r_edge;
                default:      w_rdata = '0;
            endcase
        end
    end

    assign bus_rdata = w_rdata;
    assign int_o     = r_int_o;
    assign int_id    = r_int_id;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_ctrl
// Description : Self-checking bench for int_ctrl (NSRC=8). Stimulus pushes
//               expected read data into a scoreboard queue; a monitor pops
//               and compares on every bus read cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 1;
`endif

    localparam logic [1:0] c_PEND  = 2'd0;
    localparam logic [1:0] c_MASK  = 2'd1;
    localparam logic [1:0] c_CAUSE = 2'd2;
    localparam logic [1:0] c_EDGE  = 2'd3;

    logic        clk;
    logic        reset;
    logic [7:0]  irq_i;
    logic        int_ack;
    logic        bus_sel;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        int_o;
    logic [4:0]  int_id;

    int_ctrl #(
        .NSRC       (8),
        .RESET_EDGE (32'hFFFF_FFFF)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .irq_i     (irq_i),
        .int_ack   (int_ack),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .int_o     (int_o),
        .int_id    (int_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        end_req = 1'b0;
    logic        end_ack = 1'b0;

    always @(negedge clk) begin
        if (bus_sel && !bus_we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_read: addr=%0d got=0x%08h required=none", bus_addr, bus_rdata);
            end else begin
                logic [31:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (bus_rdata !== e) begin
                    n_fail++;
                    $display("FAIL %s: got=0x%08h required=0x%08h", nm, bus_rdata, e);
                end
            end
        end
        if (end_req && !end_ack) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain: got=%0d left required=0", exp_q.size());
            end
            end_ack <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        bus_sel  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        step();
        bus_sel  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_sel   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        step();
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_i = m;
        step();
        irq_i = '0;
    endtask

    task automatic ack();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL timeout: got=running required=finished");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        reset     = 1'b0;
        irq_i     = '0;
        int_ack   = 1'b0;
        bus_sel   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        idle(3);
        reset = 1'b1;

        // Reset state
        rd(c_PEND,  32'h0000_0000, "rst_pend");
        rd(c_MASK,  32'h0000_0000, "rst_mask");
        rd(c_EDGE,  32'h0000_00FF, "rst_edge");
        rd(c_CAUSE, 32'h0000_0000, "rst_cause");

        // Single edge event, exact latency
        wr(c_MASK, 32'h05);
        pulse(8'h04);
        idle(c_LAT - 1);
        rd(c_PEND,  32'h0000_0000, "t1_pend_early");
        rd(c_CAUSE, 32'h0000_0000, "t1_cause_early");
        rd(c_CAUSE, 32'h8000_0002, "t1_cause");
        rd(c_PEND,  32'h0000_0004, "t1_pend");
        wr(c_PEND, 32'hFF);
        idle(2);
        rd(c_PEND,  32'h0000_0000, "t1_w1c_pend");
        rd(c_CAUSE, 32'h0000_0002, "t1_w1c_cause");

        // Priority and ack
        wr(c_MASK, 32'hFF);
        pulse(8'h0C);
        idle(c_LAT + 2);
        rd(c_CAUSE, 32'h8000_0002, "t2_cause_id2");
        rd(c_PEND,  32'h0000_000C, "t2_pend");
        ack();
        rd(c_PEND,  32'h0000_0008, "t2_pend_after_ack");
        rd(c_CAUSE, 32'h8000_0003, "t2_cause_id3");

        // Masking drops int_o two cycles after the write; ack while idle ignored
        wr(c_MASK, 32'h00);
        rd(c_CAUSE, 32'h8000_0003, "t5_cause_w1");
        rd(c_CAUSE, 32'h0000_0003, "t5_cause_w2");
        ack();
        rd(c_PEND,  32'h0000_0008, "t5_ack_ignored");
        wr(c_PEND, 32'h08);
        wr(c_MASK, 32'hFF);
        idle(2);
        rd(c_CAUSE, 32'h0000_0003, "t5_cause_idle");

        // Level source ignores W1C and follows the line
        wr(c_EDGE, 32'hFD);
        irq_i = 8'h02;
        idle(c_LAT + 2);
        rd(c_PEND,  32'h0000_0002, "t3_pend_level");
        rd(c_CAUSE, 32'h8000_0001, "t3_cause");
        wr(c_PEND, 32'h02);
        rd(c_PEND,  32'h0000_0002, "t3_w1c_no_effect");
        irq_i = 8'h00;
        idle(c_LAT);
        rd(c_PEND,  32'h0000_0002, "t3_pend_hold");
        rd(c_PEND,  32'h0000_0000, "t3_pend_drop");
        rd(c_CAUSE, 32'h0000_0001, "t3_cause_drop");

        // Level-to-edge switch keeps PEND
        irq_i = 8'h02;
        idle(c_LAT + 2);
        rd(c_PEND,  32'h0000_0002, "t3b_pend_level");
        wr(c_EDGE, 32'hFF);
        irq_i = 8'h00;
        idle(c_LAT + 3);
        rd(c_PEND,  32'h0000_0002, "t3b_pend_kept");
        rd(c_CAUSE, 32'h8000_0001, "t3b_cause");
        wr(c_PEND, 32'h02);
        idle(2);
        rd(c_PEND,  32'h0000_0000, "t3b_pend_clr");

        // New edge collides with W1C of the same bit: set wins
        pulse(8'h01);
        idle(c_LAT + 2);
        rd(c_PEND,  32'h0000_0001, "t4_pend_first");
        pulse(8'h01);
        idle(c_LAT - 1);
        wr(c_PEND, 32'h01);
        rd(c_PEND,  32'h0000_0001, "t4_set_wins");
        rd(c_CAUSE, 32'h8000_0000, "t4_cause");
        wr(c_PEND, 32'h01);
        rd(c_PEND,  32'h0000_0000, "t4_pend_clr");
        rd(c_CAUSE, 32'h0000_0000, "t4_cause_clr");

        // Ack and W1C in the same cycle both apply
        pulse(8'h24);
        idle(c_LAT + 2);
        rd(c_CAUSE, 32'h8000_0002, "t7_cause");
        int_ack = 1'b1;
        wr(c_PEND, 32'h20);
        int_ack = 1'b0;
        rd(c_PEND,  32'h0000_0000, "t7_pend_both_clr");
        rd(c_CAUSE, 32'h0000_0002, "t7_cause_clr");

        // Upper write bits ignored
        wr(c_MASK, 32'hFFFF_FFFF);
        rd(c_MASK,  32'h0000_00FF, "t8_mask_width");

        // Reset mid-operation
        irq_i = 8'hFF;
        idle(c_LAT + 3);
        rd(c_PEND,  32'h0000_00FF, "t6_pend_all");
        wr(c_EDGE, 32'h0F);
        idle(1);
        rd(c_PEND,  32'h0000_00FF, "t6_pend_mixed");
        rd(c_EDGE,  32'h0000_000F, "t6_edge");
        rd(c_CAUSE, 32'h8000_0000, "t6_cause");
        reset = 1'b0;
        irq_i = 8'h00;
        step();
        reset = 1'b1;
        rd(c_CAUSE, 32'h0000_0000, "t6_rst_cause");
        rd(c_PEND,  32'h0000_0000, "t6_rst_pend");
        rd(c_MASK,  32'h0000_0000, "t6_rst_mask");
        rd(c_EDGE,  32'h0000_00FF, "t6_rst_edge");

        idle(2);
        end_req = 1'b1;
        for (int k = 0; k < 10 && !end_ack; k++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
